sp_ram_arbiter: RTL and testbench
=================================

SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, RAM word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, RAM word width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ram_hold  input  1  high blocks all new grants, e.g. during RAM init or BIST access.
REQ-006 pN_req_valid  input  1  port N request valid (N = 0, 1).
REQ-007 pN_req_ready  output  1  port N request accepted this cycle.
REQ-008 pN_req_we  input  1  1 = write, 0 = read.
REQ-009 pN_req_lock  input  1  keep ownership for the next cycle (read-modify-write).
REQ-010 pN_req_addr  input  ADDR_WIDTH  word address.
REQ-011 pN_req_wdata  input  DATA_WIDTH  write data.
REQ-012 pN_req_wmask  input  DATA_WIDTH  bit write-enable mask.
REQ-013 pN_rsp_valid  output  1  read data valid, one-cycle pulse.
REQ-014 pN_rsp_rdata  output  DATA_WIDTH  read data.
REQ-015 ram_clk_en, ram_rdw_en  output  1 each  RAM access enable; 1 = write, 0 = read.
REQ-016 ram_addr, ram_data_in, ram_data_mask_in  output  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH  RAM command.
REQ-017 ram_data_out  input  DATA_WIDTH  RAM read data, valid one cycle after the read command.

Function
REQ-018 SHALL grant at most one port per cycle; pN_req_ready = grant to N, combinational from valid, hold, state and pointer.
REQ-019 With ram_hold=1, both readies SHALL be 0 and ram_clk_en SHALL be 0.
REQ-020 On a grant, the RAM command SHALL be driven from the granted port in the same cycle: ram_clk_en=1, ram_rdw_en=we, and addr/wdata/wmask passed through.
REQ-021 With no grant, ram_clk_en SHALL be 0 and the other RAM outputs SHALL be 0.
REQ-022 A granted read SHALL give pN_rsp_valid=1 exactly one cycle later, with pN_rsp_rdata=ram_data_out; a write gives no response.
REQ-023 rsp_rdata of a port SHALL be 0 whenever its rsp_valid is 0.
REQ-024 Response routing SHALL use a registered 2-bit tag (valid, port); back-to-back reads from alternating ports SHALL each route correctly.
REQ-025 The FSM SHALL have states ARB, OWN0, OWN1; reset state ARB.
REQ-026 ARB: a grant to N with pN_req_lock=1 SHALL go to OWNN; otherwise stay in ARB.
REQ-027 OWNN: only port N SHALL be grantable; a grant with lock=0 SHALL go to ARB; a grant with lock=1 SHALL stay in OWNN; no valid request SHALL keep OWNN.
REQ-028 In OWNN, ram_hold=1 SHALL block the grant but SHALL NOT release ownership.
REQ-029 The priority pointer SHALL be 1 bit, reset 0 (port 0 preferred), and SHALL update only on a grant in ARB.
REQ-030 Simultaneous valids in ARB SHALL be resolved by the pointer; a single valid SHALL be granted regardless of the pointer.

Reset
REQ-031 Asserting rst SHALL immediately force: state ARB, pointer 0, tag invalid, all readies and rsp_valid 0, rsp_rdata 0, ram_clk_en 0.
REQ-032 A read granted in the cycle before rst asserts SHALL produce no response.
REQ-033 The first grant SHALL be possible in the first clk edge after rst deasserts.

Configuration
REQ-034 Macro SP_RAM_ARB_ROUND_ROBIN_EN defined: after each ARB grant to N, the pointer SHALL become 1-N.
REQ-035 Macro undefined: the pointer SHALL be held at 0, giving fixed priority to port 0; lock behaviour is unchanged.

Verification
REQ-036 Port 0 writes 0xA5 to address 3, then reads address 3 -> p0_rsp_valid one cycle after the read grant, rdata=0xA5, p1_rsp_valid=0.
REQ-037 Both ports hold valid reads for 4 cycles with the macro defined -> grants 0,1,0,1; without the macro -> grants 0,0,0,0.
REQ-038 p1 read with lock=1, then write with lock=0, while p0 is valid throughout -> p0_req_ready=0 for both cycles, then FSM returns to ARB and p0 is granted.
REQ-039 ram_hold=1 for 3 cycles with both ports valid -> no readies, ram_clk_en=0; the grant resumes on the cycle ram_hold drops.
REQ-040 Read granted, then rst pulses asynchronously mid-cycle -> outputs clear immediately, no rsp_valid, state ARB, pointer 0.
REQ-041 Alternating reads p0 at address 1, p1 at address 2 every cycle -> each rsp goes to the issuing port with the correct data, and there are no gaps.

Source files
------------

// File: rtl/sp_ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM with lock ownership.
// Optional macro SP_RAM_ARB_ROUND_ROBIN_EN: round-robin pointer, else port 0 fixed priority.
module sp_ram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ram_hold,
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic                  p0_req_lock,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    input  logic [DATA_WIDTH-1:0] p0_req_wmask,
    output logic                  p0_rsp_valid,
    output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_we,
    input  logic                  p1_req_lock,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    input  logic [DATA_WIDTH-1:0] p1_req_wmask,
    output logic                  p1_rsp_valid,
    output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
    output logic                  ram_clk_en,
    output logic                  ram_rdw_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [DATA_WIDTH-1:0] ram_data_mask_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       ptr_q, ptr_d;
    // tag: [1] read outstanding, [0] issuing port
    logic [1:0] tag_q, tag_d;

    logic gnt0, gnt1, gnt_any, gnt_we, gnt_lock;

    // Grant selection: ownership restricts, pointer breaks ties in ARB
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && !ram_hold) begin
            case (state_q)
                ARB: begin
                    if (p0_req_valid && p1_req_valid) begin
                        gnt0 = ~ptr_q;
                        gnt1 = ptr_q;
                    end else begin
                        gnt0 = p0_req_valid;
                        gnt1 = p1_req_valid;
                    end
                end
                OWN0:    gnt0 = p0_req_valid;
                OWN1:    gnt1 = p1_req_valid;
                default: ;
            endcase
        end
    end

    assign p0_req_ready = gnt0;
    assign p1_req_ready = gnt1;
    assign gnt_any      = gnt0 | gnt1;
    assign gnt_we       = gnt1 ? p1_req_we   : p0_req_we;
    assign gnt_lock     = gnt1 ? p1_req_lock : p0_req_lock;

    // RAM command mux; all zero when nothing is granted
    always_comb begin
        ram_clk_en       = gnt_any;
        ram_rdw_en       = 1'b0;
        ram_addr         = '0;
        ram_data_in      = '0;
        ram_data_mask_in = '0;
        if (gnt1) begin
            ram_rdw_en       = p1_req_we;
            ram_addr         = p1_req_addr;
            ram_data_in      = p1_req_wdata;
            ram_data_mask_in = p1_req_wmask;
        end else if (gnt0) begin
            ram_rdw_en       = p0_req_we;
            ram_addr         = p0_req_addr;
            ram_data_in      = p0_req_wdata;
            ram_data_mask_in = p0_req_wmask;
        end
    end

    // Ownership FSM, priority pointer and response tag next-state
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        tag_d   = {gnt_any & ~gnt_we, gnt1};
        case (state_q)
            ARB: begin
                if (gnt_any) begin
                    if (gnt_lock) begin
                        state_d = gnt1 ? OWN1 : OWN0;
                    end
`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
                    ptr_d = ~gnt1;
`endif
                end
            end
            OWN0, OWN1: begin
                if (gnt_any && !gnt_lock) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
`ifndef SP_RAM_ARB_ROUND_ROBIN_EN
        ptr_d = 1'b0;
`endif
    end

    // State registers, cleared asynchronously so an in-flight read is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB;
            ptr_q   <= 1'b0;
            tag_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            tag_q   <= tag_d;
        end
    end

    assign p0_rsp_valid = tag_q[1] & ~tag_q[0];
    assign p1_rsp_valid = tag_q[1] &  tag_q[0];
    assign p0_rsp_rdata = p0_rsp_valid ? ram_data_out : '0;
    assign p1_rsp_rdata = p1_rsp_valid ? ram_data_out : '0;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Randomized scoreboard bench for sp_ram_arbiter with an in-bench RAM
// and a rule-level reference model of grants, ownership and memory.
module tb_sp_ram_arbiter;

    localparam int AW = 10;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold = 1'b0;

    logic          v[2];
    logic          we[2];
    logic          lk[2];
    logic [AW-1:0] ad[2];
    logic [DW-1:0] wd[2];
    logic [DW-1:0] wm[2];

    logic          rdy0, rdy1, rv0, rv1;
    logic [DW-1:0] rd0, rd1;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_din, ram_msk;
    logic [DW-1:0] ram_dout = '0;

    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .ram_hold(hold),
        .p0_req_valid(v[0]), .p0_req_ready(rdy0),
        .p0_req_we(we[0]), .p0_req_lock(lk[0]),
        .p0_req_addr(ad[0]), .p0_req_wdata(wd[0]),
        .p0_req_wmask(wm[0]),
        .p0_rsp_valid(rv0), .p0_rsp_rdata(rd0),
        .p1_req_valid(v[1]), .p1_req_ready(rdy1),
        .p1_req_we(we[1]), .p1_req_lock(lk[1]),
        .p1_req_addr(ad[1]), .p1_req_wdata(wd[1]),
        .p1_req_wmask(wm[1]),
        .p1_rsp_valid(rv1), .p1_rsp_rdata(rd1),
        .ram_clk_en(ram_en), .ram_rdw_en(ram_we),
        .ram_addr(ram_a), .ram_data_in(ram_din),
        .ram_data_mask_in(ram_msk), .ram_data_out(ram_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Environment RAM: masked write, one-cycle read latency
    bit [DW-1:0] ram [1024];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we)
                ram[ram_a] = (ram[ram_a] & ~ram_msk) | (ram_din & ram_msk);
            else
                ram_dout <= ram[ram_a];
        end
    end

    // Reference model
    bit [DW-1:0] mmem [1024];
    int owner = -1;
    int ptr = 0;

    typedef struct {
        int          port;
        logic [DW-1:0] data;
        int          due;
    } exp_t;
    exp_t q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic set_port(int p, bit vv, bit w, bit l, int a,
                            logic [DW-1:0] d, logic [DW-1:0] m);
        v[p]  = vv;
        we[p] = w;
        lk[p] = l;
        ad[p] = AW'(a);
        wd[p] = d;
        wm[p] = m;
    endtask

    task automatic idle();
        set_port(0, 0, 0, 0, 0, '0, '0);
        set_port(1, 0, 0, 0, 0, '0, '0);
        hold = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Compare this cycle's grant and RAM command against the model
    task automatic go();
        int g;
        @(negedge clk);
        g = -1;
        if (!hold) begin
            if (owner >= 0) begin
                if (v[owner]) g = owner;
            end else if (v[0] && v[1]) g = ptr;
            else if (v[0]) g = 0;
            else if (v[1]) g = 1;
        end
        chk("p0_ready", {63'd0, rdy0}, {63'd0, g == 0});
        chk("p1_ready", {63'd0, rdy1}, {63'd0, g == 1});
        chk("ram_clk_en", {63'd0, ram_en}, {63'd0, g >= 0});
        if (g < 0) begin
            chk("ram_rdw_idle", {63'd0, ram_we}, '0);
            chk("ram_addr_idle", {54'd0, ram_a}, '0);
            chk("ram_din_idle", ram_din, '0);
            chk("ram_mask_idle", ram_msk, '0);
        end else begin
            chk("ram_rdw_en", {63'd0, ram_we}, {63'd0, we[g]});
            chk("ram_addr", {54'd0, ram_a}, {54'd0, ad[g]});
            chk("ram_data_in", ram_din, wd[g]);
            chk("ram_mask", ram_msk, wm[g]);
            if (we[g])
                mmem[ad[g]] = (mmem[ad[g]] & ~wm[g]) | (wd[g] & wm[g]);
            else
                q.push_back('{g, mmem[ad[g]], cyc + 1});
            if (owner < 0) begin
                if (lk[g]) owner = g;
`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
                ptr = 1 - g;
`endif
            end else if (!lk[g]) begin
                owner = -1;
            end
        end
    endtask

    // Response monitor: pops the scoreboard whenever a response appears
    always @(negedge clk) begin
        if (!rst) begin
            if (!rv0) chk("p0_rdata_idle", rd0, '0);
            if (!rv1) chk("p1_rdata_idle", rd1, '0);
            if (rv0 || rv1) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp @cyc %0d: got rsp %b%b expected none",
                             cyc, rv1, rv0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rsp_both", {63'd0, rv0 & rv1}, '0);
                    chk("rsp_port", {63'd0, rv1}, DW'(e.port));
                    chk("rsp_cycle", DW'(cyc), DW'(e.due));
                    chk("rsp_data", rv1 ? rd1 : rd0, e.data);
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_rsp @cyc %0d: got none expected port %0d",
                         cyc, q[0].port);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [DW-1:0] r;
        idle();
        for (int i = 0; i < 8; i++) begin
            r = {$urandom, $urandom};
            ram[i] = r;
            mmem[i] = r;
        end
        // Reset state with requests pending
        set_port(0, 1, 0, 0, 1, '0, '0);
        set_port(1, 1, 0, 0, 2, '0, '0);
        #12;
        chk("rst_p0_ready", {63'd0, rdy0}, '0);
        chk("rst_p1_ready", {63'd0, rdy1}, '0);
        chk("rst_ram_en", {63'd0, ram_en}, '0);
        chk("rst_rsp", {62'd0, rv1, rv0}, '0);
        chk("rst_rdata", rd0 | rd1, '0);
        idle();
        @(negedge clk);
        rst = 1'b0;

        // Both ports reading for four cycles
        repeat (4) begin
            nxt();
            set_port(0, 1, 0, 0, 4, '0, '0);
            set_port(1, 1, 0, 0, 5, '0, '0);
            go();
        end

        // p0 write 0xA5 to 3 then read it back
        nxt(); idle();
        set_port(0, 1, 1, 0, 3, 64'hA5, '1);
        go();
        nxt(); idle();
        set_port(0, 1, 0, 0, 3, '0, '0);
        go();
        nxt(); idle(); go();
        chk("a5_model", mmem[3], 64'hA5);

        // p1 locked read-modify-write while p0 waits
        nxt(); idle();
        set_port(0, 1, 0, 0, 1, '0, '0);
        set_port(1, 1, 0, 1, 6, '0, '0);
        if (owner < 0 && ptr == 0) set_port(0, 0, 0, 0, 1, '0, '0);
        go();
        nxt();
        set_port(0, 1, 0, 0, 1, '0, '0);
        set_port(1, 1, 1, 0, 6, 64'h1234, 64'hFFFF);
        go();
        nxt();
        set_port(1, 0, 0, 0, 0, '0, '0);
        go();

        // RAM hold for 3 cycles with both valid
        repeat (3) begin
            nxt();
            set_port(0, 1, 0, 0, 2, '0, '0);
            set_port(1, 1, 0, 0, 7, '0, '0);
            hold = 1'b1;
            go();
        end
        nxt(); hold = 1'b0; go();

        // Alternating back-to-back reads
        for (int i = 0; i < 8; i++) begin
            nxt(); idle();
            if (i % 2 == 0) set_port(0, 1, 0, 0, 1, '0, '0);
            else            set_port(1, 1, 0, 0, 2, '0, '0);
            go();
        end

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            nxt();
            for (int p = 0; p < 2; p++)
                set_port(p, $urandom_range(0, 2) != 0,
                         $urandom_range(0, 2) == 0,
                         $urandom_range(0, 3) == 0,
                         $urandom_range(0, 7),
                         {$urandom, $urandom}, {$urandom, $urandom});
            hold = ($urandom_range(0, 7) == 0);
            go();
        end

        // Read granted, then asynchronous reset mid-cycle
        nxt(); idle();
        set_port(0, 1, 0, 0, 1, '0, '0);
        set_port(1, 1, 0, 0, 2, '0, '0);
        go();
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        chk("arst_p0_ready", {63'd0, rdy0}, '0);
        chk("arst_p1_ready", {63'd0, rdy1}, '0);
        chk("arst_ram_en", {63'd0, ram_en}, '0);
        chk("arst_rsp", {62'd0, rv1, rv0}, '0);
        chk("arst_rdata", rd0 | rd1, '0);
        @(posedge clk);
        #1;
        chk("arst_no_rsp", {62'd0, rv1, rv0}, '0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        owner = -1;
        ptr = 0;
        nxt();
        set_port(0, 1, 0, 0, 1, '0, '0);
        set_port(1, 1, 0, 0, 2, '0, '0);
        go();

        repeat (3) begin
            nxt(); idle(); go();
        end
        chk("queue_drained", DW'(q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
